// File: rtl/wide_addsub_seq_pkg.sv
// Shared types and constants for the wide add/subtract sequencer.
package wide_addsub_pkg;

  localparam int unsigned DefaultW     = 64;
  localparam int unsigned DefaultWords = 4;

  localparam logic ModeAdd = 1'b0;
  localparam logic ModeSub = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/wide_addsub_seq_if.sv
// Command/result bus of the wide add/subtract sequencer.
interface wide_addsub_seq_if #(
  parameter int unsigned W     = wide_addsub_pkg::DefaultW,
  parameter int unsigned WORDS = wide_addsub_pkg::DefaultWords
);

  localparam int unsigned N = W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         SF;
  logic         CF;
  logic         OF;
  logic         PF;
  logic         ZF;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, result, SF, CF, OF, PF, ZF
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, result, SF, CF, OF, PF, ZF
  );

endinterface

// File: rtl/wide_addsub_seq_add64_slice.sv
// Combinational W-bit adder slice; also exposes the carry into the MSB for overflow.
module add64_slice #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] low;
  logic [1:0]   high;

  // Split the add so the carry into the top bit is visible.
  assign low   = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + W'(cin);
  assign c_msb = low[W-1];
  assign high  = {1'b0, x[W-1]} + {1'b0, y[W-1]} + {1'b0, c_msb};
  assign sum   = {high[0], low[W-2:0]};
  assign cout  = high[1];

endmodule

// File: rtl/wide_addsub_seq.sv
// Multi-precision add/subtract sequencer: one W-bit slice, WORDS passes, LS word first.
// Optional flag logic enabled by defining WIDE_ADDSUB_FLAGS_EN; otherwise flags read 0.
module wide_addsub_seq
  import wide_addsub_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned WORDS = DefaultWords
) (
  input logic              clk,
  input logic              rst_n,
  wide_addsub_seq_if.slave bus
);

  localparam int unsigned N    = W * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    result_q, result_d;
  logic            mode_q, mode_d;
  logic            carry_q, carry_d;
  logic            out_valid_q, out_valid_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic [W-1:0]    slice_x, slice_y, slice_sum;
  logic            slice_cout;
  logic [N-1:0]    res_full;
`ifdef WIDE_ADDSUB_FLAGS_EN
  logic            slice_cmsb;
`endif

  // Subtract is A + ~B + 1: invert B and seed the carry with the mode.
  assign slice_x = a_q[idx_q*W +: W];
  assign slice_y = b_q[idx_q*W +: W] ^ {W{mode_q == ModeSub}};

  add64_slice #(
    .W (W)
  ) u_slice (
    .x     (slice_x),
    .y     (slice_y),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
`ifdef WIDE_ADDSUB_FLAGS_EN
    .c_msb (slice_cmsb)
`else
    .c_msb ()
`endif
  );

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  // FSM next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    res_full    = acc_q;
    res_full[idx_q*W +: W] = slice_sum;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          idx_d   = '0;
          carry_d = (bus.mode == ModeAdd) ? 1'b0 : 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d   = res_full;
        carry_d = slice_cout;
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          // Visible result only updates on entry to DONE.
          result_d    = res_full;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
    end
  end

`ifdef WIDE_ADDSUB_FLAGS_EN
  logic sf_q, cf_q, of_q, pf_q, zf_q, zero_q;
  logic slice_zero;

  assign slice_zero = (slice_sum == '0);

  // Running zero accumulator and flag capture on the final slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      sf_q   <= 1'b0;
      cf_q   <= 1'b0;
      of_q   <= 1'b0;
      pf_q   <= 1'b0;
      zf_q   <= 1'b0;
    end else if (state_q == StIdle && bus.in_valid) begin
      zero_q <= 1'b1;
    end else if (state_q == StRun) begin
      zero_q <= zero_q & slice_zero;
      if (idx_q == LastIdx) begin
        sf_q <= res_full[N-1];
        cf_q <= slice_cout ^ (mode_q != ModeAdd);
        of_q <= slice_cmsb ^ slice_cout;
        pf_q <= ~^res_full[7:0];
        zf_q <= zero_q & slice_zero;
      end
    end
  end

  assign bus.SF = sf_q;
  assign bus.CF = cf_q;
  assign bus.OF = of_q;
  assign bus.PF = pf_q;
  assign bus.ZF = zf_q;
`else
  assign bus.SF = 1'b0;
  assign bus.CF = 1'b0;
  assign bus.OF = 1'b0;
  assign bus.PF = 1'b0;
  assign bus.ZF = 1'b0;
`endif

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Randomized self-checking bench for wide_addsub_seq against an arithmetic reference model.
module tb_wide_addsub_seq;
  import wide_addsub_pkg::*;

  localparam int unsigned W     = 64;
  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = W * WORDS;
  localparam int          Bound = 50;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  wide_addsub_seq_if #(.W(W), .WORDS(WORDS)) bus ();

  wide_addsub_seq #(
    .W     (W),
    .WORDS (WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] rand_n();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < (N + 31) / 32; i++) v = (v << 32) | N'($urandom);
    return v;
  endfunction

  // Reference: plain N-bit arithmetic, flags {SF,CF,OF,PF,ZF}.
  function automatic void model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                input logic mv, output logic [N-1:0] r,
                                output logic [4:0] f);
    logic [N:0] full;
    logic       cf, ovf;
    if (mv == ModeAdd) begin
      full = {1'b0, av} + {1'b0, bv};
      r    = full[N-1:0];
      cf   = full[N];
      ovf  = (av[N-1] == bv[N-1]) && (r[N-1] != av[N-1]);
    end else begin
      r    = av - bv;
      cf   = (av < bv);
      ovf  = (av[N-1] != bv[N-1]) && (r[N-1] != av[N-1]);
    end
`ifdef WIDE_ADDSUB_FLAGS_EN
    f = {r[N-1], cf, ovf, ~^r[7:0], (r == '0)};
`else
    f = 5'b0;
`endif
  endfunction

  function automatic logic [4:0] obs_flags();
    return {bus.SF, bus.CF, bus.OF, bus.PF, bus.ZF};
  endfunction

  // Present a command while the DUT is idle; returns 1 ns after the accepting edge.
  task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic mv);
    bus.a        = av;
    bus.b        = bv;
    bus.mode     = mv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Operands must be ignored once accepted.
    bus.a        = rand_n();
    bus.b        = rand_n();
    bus.mode     = ~mv;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < Bound) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    tests_run++;
    if (bus.result !== '0) begin
      tests_failed++;
      $display("FAIL reset_result: got %h want 0", bus.result);
    end
    tests_run++;
    if (obs_flags() !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 00000", obs_flags());
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] ta[3];
    logic [N-1:0] tb[3];
    logic         tm[3];
    logic [N-1:0] tr[3];
    logic [4:0]   tf[3];
    logic [4:0]   ef;
    int           lat;
    ta[0] = '1;                      tb[0] = N'(1); tm[0] = ModeAdd;
    tr[0] = '0;                      tf[0] = 5'b01011;
    ta[1] = '0;                      tb[1] = N'(1); tm[1] = ModeSub;
    tr[1] = '1;                      tf[1] = 5'b11010;
    ta[2] = {1'b0, {(N-1){1'b1}}};   tb[2] = N'(1); tm[2] = ModeAdd;
    tr[2] = {1'b1, {(N-1){1'b0}}};   tf[2] = 5'b10110;
    for (int i = 0; i < 3; i++) begin
`ifdef WIDE_ADDSUB_FLAGS_EN
      ef = tf[i];
`else
      ef = 5'b0;
`endif
      start_op(ta[i], tb[i], tm[i]);
      tests_run++;
      if (bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL dir%0d_busy_in_ready: got %b want 0", i, bus.in_ready);
      end
      wait_done(lat);
      tests_run++;
      if (lat != int'(WORDS)) begin
        tests_failed++;
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, WORDS);
      end
      tests_run++;
      if (bus.result !== tr[i]) begin
        tests_failed++;
        $display("FAIL dir%0d_result: got %h want %h", i, bus.result, tr[i]);
      end
      tests_run++;
      if (obs_flags() !== ef) begin
        tests_failed++;
        $display("FAIL dir%0d_flags: got %b want %b", i, obs_flags(), ef);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] av, bv, er;
    logic [4:0]   ef;
    logic         mv;
    int           lat;
    for (int i = 0; i < 24; i++) begin
      av = rand_n();
      bv = rand_n();
      mv = 1'(i % 2);
      case ($urandom_range(0, 3))
        0: bv = av;
        1: begin av = '1; bv = N'($urandom_range(0, 3)); end
        2: av = {1'b0, {(N-1){1'b1}}} + N'($urandom_range(0, 2));
        default: ;
      endcase
      model(av, bv, mv, er, ef);
      start_op(av, bv, mv);
      wait_done(lat);
      tests_run++;
      if (lat != int'(WORDS) || bus.result !== er || obs_flags() !== ef) begin
        tests_failed++;
        $display("FAIL rand%0d: lat %0d res %h flags %b, want lat %0d res %h flags %b",
                 i, lat, bus.result, obs_flags(), WORDS, er, ef);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] av, bv, er, nav, nbv, ner;
    logic [4:0]   ef, nef;
    int           lat;
    av = rand_n();
    bv = rand_n();
    model(av, bv, ModeSub, er, ef);
    nav = rand_n();
    nbv = rand_n();
    model(nav, nbv, ModeAdd, ner, nef);
    start_op(av, bv, ModeSub);
    wait_done(lat);
    bus.a        = nav;
    bus.b        = nbv;
    bus.mode     = ModeAdd;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== er ||
          obs_flags() !== ef) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: ov %b ir %b res %h flags %b, want ov 1 ir 0 res %h flags %b",
                 c, bus.out_valid, bus.in_ready, bus.result, obs_flags(), er, ef);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_handoff: ov %b ir %b want ov 0 ir 1", bus.out_valid, bus.in_ready);
    end
    start_op(nav, nbv, ModeAdd);
    wait_done(lat);
    tests_run++;
    if (lat != int'(WORDS) || bus.result !== ner || obs_flags() !== nef) begin
      tests_failed++;
      $display("FAIL bp_next: lat %0d res %h flags %b, want lat %0d res %h flags %b",
               lat, bus.result, obs_flags(), WORDS, ner, nef);
    end
    release_out();
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] er;
    logic [4:0]   ef;
    int           lat;
    start_op(rand_n() | N'(1), rand_n(), ModeAdd);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== '0 ||
        obs_flags() !== 5'b0) begin
      tests_failed++;
      $display("FAIL midrun_reset: ov %b ir %b res %h flags %b, want ov 0 ir 1 res 0 flags 0",
               bus.out_valid, bus.in_ready, bus.result, obs_flags());
    end
    rst_n = 1'b1;
    model(N'(5), N'(3), ModeSub, er, ef);
    start_op(N'(5), N'(3), ModeSub);
    wait_done(lat);
    tests_run++;
    if (lat != int'(WORDS) || bus.result !== N'(2) || bus.result !== er ||
        bus.CF !== 1'b0 || obs_flags() !== ef) begin
      tests_failed++;
      $display("FAIL midrun_next: lat %0d res %h flags %b, want lat %0d res 2 flags %b",
               lat, bus.result, obs_flags(), WORDS, ef);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] qr[$];
    logic [4:0]   qf[$];
    logic [N-1:0] er;
    logic [4:0]   ef;
    logic         acc;
    int           last_acc;
    int           n_acc;
    last_acc      = -1;
    n_acc         = 0;
    bus.a         = rand_n();
    bus.b         = rand_n();
    bus.mode      = 1'($urandom);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c == 40) bus.in_valid = 1'b0;
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        if (last_acc >= 0) begin
          tests_run++;
          if (c - last_acc < int'(WORDS) + 1) begin
            tests_failed++;
            $display("FAIL b2b_interval: got %0d want >= %0d", c - last_acc, WORDS + 1);
          end
        end
        last_acc = c;
        n_acc++;
        model(bus.a, bus.b, bus.mode, er, ef);
        qr.push_back(er);
        qf.push_back(ef);
      end
      if (bus.out_valid === 1'b1) begin
        tests_run++;
        if (qr.size() == 0) begin
          tests_failed++;
          $display("FAIL b2b_spurious: out_valid with no command outstanding, want none");
        end else begin
          er = qr.pop_front();
          ef = qf.pop_front();
          if (bus.result !== er || obs_flags() !== ef) begin
            tests_failed++;
            $display("FAIL b2b_result: res %h flags %b want res %h flags %b",
                     bus.result, obs_flags(), er, ef);
          end
        end
      end
      @(posedge clk);
      #1;
      if (acc) begin
        bus.a    = rand_n();
        bus.b    = rand_n();
        bus.mode = 1'($urandom);
      end
    end
    bus.out_ready = 1'b0;
    tests_run++;
    if (qr.size() != 0 || n_acc < 5) begin
      tests_failed++;
      $display("FAIL b2b_drain: pending %0d accepted %0d, want pending 0 accepted >= 5",
               qr.size(), n_acc);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.mode      = ModeAdd;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
